// File: rtl/floo_pkg.sv
// Shared helpers for the floo buffered link blocks.
package floo_pkg;

  // Counter width able to represent 0..depth inclusive.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/floo_link_delay_chan.sv
// One link channel: fixed-latency delay line feeding a credit-limited
// non-fall-through FIFO, with occupancy and transfer counters.
module floo_link_delay_chan import floo_pkg::*; #(
  parameter type          flit_t      = logic,
  parameter int unsigned  Latency     = 2,
  parameter int unsigned  BufferDepth = 4,
  parameter int unsigned  CntWidth    = 32,
  localparam int unsigned OccW        = occ_width(BufferDepth),
  localparam int unsigned PtrW        = (BufferDepth > 1) ? $clog2(BufferDepth) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                valid_i,
  output logic                ready_o,
  input  flit_t               data_i,
  output logic                valid_o,
  input  logic                ready_i,
  output flit_t               data_o,
  input  logic                stall_i,
  output logic [OccW-1:0]     occupancy_o,
  output logic [CntWidth-1:0] xfer_cnt_o
);

  logic                in_hs, out_hs;
  logic                wr_vld;
  flit_t               wr_data;
  logic [OccW-1:0]     occ_q, occ_d, fcnt_q, fcnt_d;
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0] xfer_q;
  logic                fifo_empty, fifo_full;
  flit_t               mem_q [BufferDepth];

  // Credits cover delay line plus FIFO, so ready needs no downstream path.
  assign ready_o    = occ_q < OccW'(BufferDepth);
  assign in_hs      = valid_i & ready_o;
  assign fifo_empty = (fcnt_q == '0);
  assign fifo_full  = (fcnt_q == OccW'(BufferDepth));
  assign valid_o    = ~fifo_empty & ~stall_i;
  assign out_hs     = valid_o & ready_i;
  assign data_o     = mem_q[rd_ptr_q];

  assign occupancy_o = occ_q;
  assign xfer_cnt_o  = xfer_q;

  if (Latency == 1) begin : g_direct
    assign wr_vld  = in_hs;
    assign wr_data = data_i;
  end else begin : g_dline
    localparam int unsigned Stg = Latency - 1;
    logic [Stg-1:0] vld_q;
    flit_t          dat_q [Stg];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q <= '0;
        for (int s = 0; s < Stg; s++) dat_q[s] <= '0;
      end else begin
        vld_q[0] <= in_hs;
        dat_q[0] <= data_i;
        for (int s = 1; s < Stg; s++) begin
          vld_q[s] <= vld_q[s-1];
          dat_q[s] <= dat_q[s-1];
        end
      end
    end

    assign wr_vld  = vld_q[Stg-1];
    assign wr_data = dat_q[Stg-1];
  end

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(BufferDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    occ_d = occ_q;
    case ({in_hs, out_hs})
      2'b10:   occ_d = occ_q + OccW'(1);
      2'b01:   occ_d = occ_q - OccW'(1);
      default: occ_d = occ_q;
    endcase
    fcnt_d = fcnt_q;
    case ({wr_vld, out_hs})
      2'b10:   fcnt_d = fcnt_q + OccW'(1);
      2'b01:   fcnt_d = fcnt_q - OccW'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q    <= '0;
      fcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      xfer_q   <= '0;
      for (int e = 0; e < BufferDepth; e++) mem_q[e] <= '0;
    end else begin
      occ_q  <= occ_d;
      fcnt_q <= fcnt_d;
      xfer_q <= xfer_q + CntWidth'(out_hs);
      if (wr_vld) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (out_hs) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

`ifndef SYNTHESIS
  a_occ_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    occ_q <= OccW'(BufferDepth));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(wr_vld && fifo_full));
`endif

endmodule

// File: rtl/floo_link_delay_pipe.sv
// Multi-channel fixed-latency link between two chimneys; channels are
// independent, idle_o reports that every channel has drained.
module floo_link_delay_pipe import floo_pkg::*; #(
  parameter int unsigned NumChannels = 3,
  parameter type         flit_t      = logic,
  parameter int unsigned Latency     = 2,
  parameter int unsigned BufferDepth = 4,
  parameter int unsigned CntWidth    = 32
) (
  input  logic                                                   clk_i,
  input  logic                                                   rst_ni,
  input  logic  [NumChannels-1:0]                                valid_i,
  output logic  [NumChannels-1:0]                                ready_o,
  input  flit_t [NumChannels-1:0]                                data_i,
  output logic  [NumChannels-1:0]                                valid_o,
  input  logic  [NumChannels-1:0]                                ready_i,
  output flit_t [NumChannels-1:0]                                data_o,
  input  logic  [NumChannels-1:0]                                stall_i,
  output logic  [NumChannels-1:0][occ_width(BufferDepth)-1:0]    occupancy_o,
  output logic  [NumChannels-1:0][CntWidth-1:0]                  xfer_cnt_o,
  output logic                                                   idle_o
);

  if (Latency < 1)     begin : g_bad_lat   $fatal(1, "Latency must be >= 1");     end
  if (BufferDepth < 1) begin : g_bad_depth $fatal(1, "BufferDepth must be >= 1"); end
  if (NumChannels < 1) begin : g_bad_nch   $fatal(1, "NumChannels must be >= 1"); end

  logic [NumChannels-1:0] chan_idle;

  for (genvar i = 0; i < NumChannels; i++) begin : g_chan
    floo_link_delay_chan #(
      .flit_t      (flit_t),
      .Latency     (Latency),
      .BufferDepth (BufferDepth),
      .CntWidth    (CntWidth)
    ) i_chan (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .valid_i     (valid_i[i]),
      .ready_o     (ready_o[i]),
      .data_i      (data_i[i]),
      .valid_o     (valid_o[i]),
      .ready_i     (ready_i[i]),
      .data_o      (data_o[i]),
      .stall_i     (stall_i[i]),
      .occupancy_o (occupancy_o[i]),
      .xfer_cnt_o  (xfer_cnt_o[i])
    );
    assign chan_idle[i] = (occupancy_o[i] == '0);
  end

  assign idle_o = &chan_idle;

endmodule
